// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC measurement sequencer.
package agc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TICK,
    RUN,
    FLUSH,
    CAPTURE
  } agc_state_t;

  localparam int SCALE_BITS  = 17;
  localparam int OFFSET_BITS = 8;

  // Scale value that leaves the signal level unchanged (Q12 unity).
  localparam logic [SCALE_BITS-1:0] AGC_UNITY_SCALE = 17'd4096;

  localparam int DEFAULT_NCLK_LOG2  = 17;
  localparam int DEFAULT_FLUSH_CLKS = 4;

endpackage

// File: rtl/agc_sequencer_if.sv
// Bundle of control, accumulator, capture and gain signals between the
// AGC sequencer (slave) and the block that controls it (master).
interface agc_sequencer_if #(
  parameter int SQ_BITS = 24,
  parameter int PR_BITS = 21
);
  import agc_pkg::*;

  logic                   enable_i;
  logic                   start_i;
  logic                   lfsr_reset_i;
  logic                   busy_o;

  logic                   agc_tick_o;
  logic                   agc_ce_o;
  logic                   agc_rst_o;

  logic [SQ_BITS-1:0]     sq_accum_i;
  logic [PR_BITS-1:0]     gt_accum_i;
  logic [PR_BITS-1:0]     lt_accum_i;

  logic [SQ_BITS-1:0]     sq_o;
  logic [PR_BITS-1:0]     gt_o;
  logic [PR_BITS-1:0]     lt_o;
  logic                   done_o;

  logic [SCALE_BITS-1:0]  scale_i;
  logic [OFFSET_BITS-1:0] offset_i;
  logic                   scale_wr_i;
  logic                   offset_wr_i;
  logic                   apply_i;

  logic [SCALE_BITS-1:0]  agc_scale_o;
  logic [OFFSET_BITS-1:0] agc_offset_o;
  logic                   agc_scale_ce_o;
  logic                   agc_offset_ce_o;
  logic                   agc_apply_o;

  modport master (
    output enable_i, start_i, lfsr_reset_i,
    output sq_accum_i, gt_accum_i, lt_accum_i,
    output scale_i, offset_i, scale_wr_i, offset_wr_i, apply_i,
    input  busy_o, agc_tick_o, agc_ce_o, agc_rst_o,
    input  sq_o, gt_o, lt_o, done_o,
    input  agc_scale_o, agc_offset_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o
  );

  modport slave (
    input  enable_i, start_i, lfsr_reset_i,
    input  sq_accum_i, gt_accum_i, lt_accum_i,
    input  scale_i, offset_i, scale_wr_i, offset_wr_i, apply_i,
    output busy_o, agc_tick_o, agc_ce_o, agc_rst_o,
    output sq_o, gt_o, lt_o, done_o,
    output agc_scale_o, agc_offset_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o
  );

endinterface

// File: rtl/agc_gain_stage.sv
// Gain staging: loads scale/offset with a one-cycle ce strobe and holds an
// apply request until the sequencer is idle, so a new gain never lands
// in the middle of a measurement window.
module agc_gain_stage
  import agc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idle,
  input  logic [SCALE_BITS-1:0]  scale_req,
  input  logic                   scale_wr,
  input  logic [OFFSET_BITS-1:0] offset_req,
  input  logic                   offset_wr,
  input  logic                   apply_req,
  output logic [SCALE_BITS-1:0]  scale,
  output logic                   scale_ce,
  output logic [OFFSET_BITS-1:0] offset,
  output logic                   offset_ce,
  output logic                   apply_pulse,
  output logic                   apply_fire
);

  logic pending;

  // A pending apply is released in the first idle cycle; the pulse follows one cycle later.
  assign apply_fire = pending && idle;

  // Scale and offset load independently; value and ce appear together the cycle after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale     <= AGC_UNITY_SCALE;
      scale_ce  <= 1'b0;
      offset    <= '0;
      offset_ce <= 1'b0;
    end else begin
      scale_ce  <= scale_wr;
      offset_ce <= offset_wr;
      if (scale_wr) scale <= scale_req;
      if (offset_wr) offset <= offset_req;
    end
  end

  // Repeated requests while pending merge into the one flag; it clears when released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      apply_pulse <= 1'b0;
    end else begin
      pending     <= apply_req || (pending && !apply_fire);
      apply_pulse <= apply_fire;
    end
  end

endmodule

// File: rtl/agc_sequencer.sv
// AGC measurement sequencer: ticks the AGC core, enables its accumulators
// for a 2^NCLK_LOG2-clock window, drains the pipeline, captures the
// results and stages gain updates so they only take effect between windows.
module agc_sequencer
  import agc_pkg::*;
#(
  parameter int NCLK_LOG2  = DEFAULT_NCLK_LOG2,
  parameter int FLUSH_CLKS = DEFAULT_FLUSH_CLKS,
  parameter int SQ_BITS    = 24,
  parameter int PR_BITS    = 21
) (
  input  logic           clk_i,
  input  logic           rst_i,
  agc_sequencer_if.slave bus
);

  localparam int CNT_BITS = NCLK_LOG2 + 1;
  localparam logic [CNT_BITS-1:0] RUN_LAST   = CNT_BITS'((1 << NCLK_LOG2) - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_LAST = CNT_BITS'(FLUSH_CLKS - 1);

  agc_state_t          state;
  agc_state_t          next_state;
  logic [CNT_BITS-1:0] cnt;
  logic                abort;
  logic                idle;
  logic                apply_fire;

  logic                tick_q;
  logic                ce_q;
  logic                busy_q;
  logic                done_q;
  logic                lfsr_q;
  logic [SQ_BITS-1:0]  sq_q;
  logic [PR_BITS-1:0]  gt_q;
  logic [PR_BITS-1:0]  lt_q;

  assign abort = !bus.enable_i || bus.lfsr_reset_i;
  assign idle  = (state == IDLE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: a start is held off in the cycle an apply is being released so the two never overlap.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start_i && bus.enable_i && !bus.lfsr_reset_i && !apply_fire)
          next_state = TICK;
      end
      TICK: begin
        next_state = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort)                 next_state = IDLE;
        else if (cnt == RUN_LAST)  next_state = FLUSH;
      end
      FLUSH: begin
        if (abort)                 next_state = IDLE;
        else if (cnt == FLUSH_LAST) next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Shared RUN/FLUSH cycle counter, cleared on every state change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               cnt <= '0;
    else if (next_state != state)            cnt <= '0;
    else if (state == RUN || state == FLUSH) cnt <= cnt + 1'b1;
  end

  // Core-drive strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= 1'b0;
      ce_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lfsr_q <= 1'b0;
    end else begin
      tick_q <= (next_state == TICK);
      ce_q   <= (next_state == RUN);
      busy_q <= (next_state != IDLE);
      done_q <= (state == CAPTURE);
      lfsr_q <= bus.lfsr_reset_i;
    end
  end

  // Capture the drained accumulators on leaving CAPTURE; results hold until the next capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
    end else if (state == CAPTURE) begin
      sq_q <= bus.sq_accum_i;
      gt_q <= bus.gt_accum_i;
      lt_q <= bus.lt_accum_i;
    end
  end

  assign bus.agc_tick_o = tick_q;
  assign bus.agc_ce_o   = ce_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.agc_rst_o  = lfsr_q;
  assign bus.sq_o       = sq_q;
  assign bus.gt_o       = gt_q;
  assign bus.lt_o       = lt_q;

  agc_gain_stage u_gain_stage (
    .clk         (clk_i),
    .rst         (rst_i),
    .idle        (idle),
    .scale_req   (bus.scale_i),
    .scale_wr    (bus.scale_wr_i),
    .offset_req  (bus.offset_i),
    .offset_wr   (bus.offset_wr_i),
    .apply_req   (bus.apply_i),
    .scale       (bus.agc_scale_o),
    .scale_ce    (bus.agc_scale_ce_o),
    .offset      (bus.agc_offset_o),
    .offset_ce   (bus.agc_offset_ce_o),
    .apply_pulse (bus.agc_apply_o),
    .apply_fire  (apply_fire)
  );

endmodule

// File: tb/tb_agc_sequencer.sv
// Testbench for agc_sequencer with a 16-clock window and 4 flush clocks.
module tb_agc_sequencer;
  import agc_pkg::*;

  localparam int NL  = 4;
  localparam int FC  = 4;
  localparam int WIN = 1 << NL;
  localparam int CAP = WIN + FC + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: position within the window (-1 when idle, 0 = tick cycle) plus expected outputs.
  int          m_win;
  bit          m_pend;
  logic        e_tick, e_ce, e_rst, e_busy, e_done, e_scale_ce, e_offset_ce, e_apply;
  logic [23:0] e_sq;
  logic [20:0] e_gt, e_lt;
  logic [16:0] e_scale;
  logic [7:0]  e_offset;

  always #5 clk = ~clk;

  agc_sequencer_if #(.SQ_BITS(24), .PR_BITS(21)) bus ();

  agc_sequencer #(
    .NCLK_LOG2  (NL),
    .FLUSH_CLKS (FC),
    .SQ_BITS    (24),
    .PR_BITS    (21)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic lr,
                               input logic ap, input logic sw, input logic ow);
    bus.enable_i     = en;
    bus.start_i      = st;
    bus.lfsr_reset_i = lr;
    bus.apply_i      = ap;
    bus.scale_wr_i   = sw;
    bus.offset_wr_i  = ow;
  endtask

  task automatic modelReset();
    m_win       = -1;
    m_pend      = 1'b0;
    e_tick      = 1'b0;
    e_ce        = 1'b0;
    e_rst       = 1'b0;
    e_busy      = 1'b0;
    e_done      = 1'b0;
    e_scale_ce  = 1'b0;
    e_offset_ce = 1'b0;
    e_apply     = 1'b0;
    e_sq        = '0;
    e_gt        = '0;
    e_lt        = '0;
    e_scale     = 17'd4096;
    e_offset    = '0;
  endtask

  // Advance the model across one rising edge using the inputs held across it.
  task automatic modelEdge();
    int pw;
    bit abort_req, fire;
    if (rst) begin
      modelReset();
      return;
    end
    pw        = m_win;
    abort_req = !bus.enable_i || bus.lfsr_reset_i;
    fire      = m_pend && (pw < 0);
    e_done    = (pw == CAP);
    if (pw == CAP) begin
      e_sq = bus.sq_accum_i;
      e_gt = bus.gt_accum_i;
      e_lt = bus.lt_accum_i;
    end
    if (pw < 0)
      m_win = (bus.start_i && bus.enable_i && !bus.lfsr_reset_i && !fire) ? 0 : -1;
    else if (pw == CAP || abort_req)
      m_win = -1;
    else
      m_win = pw + 1;
    m_pend      = bus.apply_i || (m_pend && !fire);
    e_apply     = fire;
    e_rst       = bus.lfsr_reset_i;
    e_scale_ce  = bus.scale_wr_i;
    e_offset_ce = bus.offset_wr_i;
    if (bus.scale_wr_i)  e_scale  = bus.scale_i;
    if (bus.offset_wr_i) e_offset = bus.offset_i;
    e_tick = (m_win == 0);
    e_ce   = (m_win >= 1) && (m_win <= WIN);
    e_busy = (m_win >= 0);
  endtask

  task automatic checkAll();
    checkOutput("agc_tick_o",      32'(bus.agc_tick_o),      32'(e_tick));
    checkOutput("agc_ce_o",        32'(bus.agc_ce_o),        32'(e_ce));
    checkOutput("agc_rst_o",       32'(bus.agc_rst_o),       32'(e_rst));
    checkOutput("busy_o",          32'(bus.busy_o),          32'(e_busy));
    checkOutput("done_o",          32'(bus.done_o),          32'(e_done));
    checkOutput("sq_o",            32'(bus.sq_o),            32'(e_sq));
    checkOutput("gt_o",            32'(bus.gt_o),            32'(e_gt));
    checkOutput("lt_o",            32'(bus.lt_o),            32'(e_lt));
    checkOutput("agc_scale_o",     32'(bus.agc_scale_o),     32'(e_scale));
    checkOutput("agc_offset_o",    32'(bus.agc_offset_o),    32'(e_offset));
    checkOutput("agc_scale_ce_o",  32'(bus.agc_scale_ce_o),  32'(e_scale_ce));
    checkOutput("agc_offset_ce_o", 32'(bus.agc_offset_ce_o), 32'(e_offset_ce));
    checkOutput("agc_apply_o",     32'(bus.agc_apply_o),     32'(e_apply));
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  // Step after a start edge until done_o, counting tick/ce cycles and the done latency in edges.
  task automatic runWindow(output int ticks, output int ces, output int lat);
    ticks = int'(bus.agc_tick_o);
    ces   = int'(bus.agc_ce_o);
    lat   = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      stepClock();
      ticks += int'(bus.agc_tick_o);
      ces   += int'(bus.agc_ce_o);
      if (bus.done_o) lat = i;
    end
  endtask

  // Bring the DUT back to a quiet idle with enable high.
  task automatic settleIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && bus.busy_o; i++) stepClock();
    checkOutput("settle_busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 3; i++) stepClock();
  endtask

  initial begin
    int ticks, ces, lat, early, late, pos;
    logic [23:0] held_sq;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.sq_accum_i = '0;
    bus.gt_accum_i = '0;
    bus.lt_accum_i = '0;
    bus.scale_i    = '0;
    bus.offset_i   = '0;
    modelReset();

    // Power-on reset.
    #1 rst = 1'b1;
    #1 checkAll();
    checkOutput("reset_scale_unity", 32'(bus.agc_scale_o), 32'd4096);
    stepClock();
    stepClock();
    rst = 1'b0;
    settleIdle();

    // Full window with a known accumulator value.
    $display("[TB] normal window");
    bus.sq_accum_i = 24'h004000;
    bus.gt_accum_i = 21'h0000AB;
    bus.lt_accum_i = 21'h0000CD;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    bus.start_i = 1'b0;
    runWindow(ticks, ces, lat);
    checkOutput("win_tick_cycles", 32'(ticks), 32'd1);
    checkOutput("win_ce_cycles",   32'(ces),   32'd16);
    checkOutput("win_done_latency", 32'(lat),  32'd22);
    checkOutput("win_sq_value", 32'(bus.sq_o), 32'h004000);
    stepClock();
    checkOutput("win_done_single", 32'(bus.done_o), 32'd0);

    // start_i while busy is ignored; enable dropped at RUN cycle 8 aborts.
    $display("[TB] enable abort");
    settleIdle();
    held_sq = bus.sq_o;
    bus.sq_accum_i = 24'h123456;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    for (int k = 1; k <= 8; k++) stepClock();
    checkOutput("abort_ce_before", 32'(bus.agc_ce_o), 32'd1);
    bus.start_i  = 1'b0;
    bus.enable_i = 1'b0;
    stepClock();
    checkOutput("abort_ce_after",   32'(bus.agc_ce_o), 32'd0);
    checkOutput("abort_busy_after", 32'(bus.busy_o),   32'd0);
    early = 0;
    for (int i = 0; i < 30; i++) begin
      stepClock();
      early += int'(bus.done_o);
    end
    checkOutput("abort_no_done",      32'(early),     32'd0);
    checkOutput("abort_sq_unchanged", 32'(bus.sq_o),  32'(held_sq));

    // Two applies mid-window merge into one pulse released after the window.
    $display("[TB] deferred apply");
    settleIdle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 3; k++) stepClock();
    bus.apply_i = 1'b1;
    stepClock();
    bus.apply_i = 1'b0;
    stepClock();
    stepClock();
    bus.apply_i = 1'b1;
    stepClock();
    bus.apply_i = 1'b0;
    early = 0;
    lat   = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      stepClock();
      early += int'(bus.agc_apply_o);
      if (bus.done_o) lat = i;
    end
    checkOutput("apply_done_seen", 32'(lat >= 0), 32'd1);
    checkOutput("apply_none_early", 32'(early), 32'd0);
    late = 0;
    pos  = 0;
    for (int j = 1; j <= 5; j++) begin
      stepClock();
      if (bus.agc_apply_o) begin
        late++;
        if (pos == 0) pos = j;
      end
    end
    checkOutput("apply_single_pulse", 32'(late), 32'd1);
    checkOutput("apply_position",     32'(pos),  32'd1);

    // Scale write coincident with apply in idle: ce first, apply next.
    $display("[TB] scale write with apply");
    settleIdle();
    bus.scale_i = 17'd8192;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_scale_ce_n1",  32'(bus.agc_scale_ce_o), 32'd1);
    checkOutput("wr_scale_val_n1", 32'(bus.agc_scale_o),    32'd8192);
    checkOutput("wr_apply_n1",     32'(bus.agc_apply_o),    32'd0);
    stepClock();
    checkOutput("wr_scale_ce_n2",  32'(bus.agc_scale_ce_o), 32'd0);
    checkOutput("wr_apply_n2",     32'(bus.agc_apply_o),    32'd1);
    stepClock();
    checkOutput("wr_apply_n3",     32'(bus.agc_apply_o),    32'd0);

    // LFSR resync mid-RUN aborts, then a fresh window completes.
    $display("[TB] lfsr resync abort and restart");
    settleIdle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 5; k++) stepClock();
    bus.lfsr_reset_i = 1'b1;
    stepClock();
    bus.lfsr_reset_i = 1'b0;
    checkOutput("lfsr_rst_o",  32'(bus.agc_rst_o), 32'd1);
    checkOutput("lfsr_ce_off", 32'(bus.agc_ce_o),  32'd0);
    stepClock();
    checkOutput("lfsr_rst_o_end", 32'(bus.agc_rst_o), 32'd0);
    settleIdle();
    bus.sq_accum_i = 24'h00ABCD;
    bus.start_i = 1'b1;
    stepClock();
    bus.start_i = 1'b0;
    runWindow(ticks, ces, lat);
    checkOutput("restart_ce_cycles",   32'(ces),       32'd16);
    checkOutput("restart_done_latency", 32'(lat),      32'd22);
    checkOutput("restart_sq_value",    32'(bus.sq_o),  32'h00ABCD);

    // Randomized traffic checked cycle by cycle against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 9) == 0),  1'($urandom_range(0, 9) == 0));
      bus.sq_accum_i = 24'($urandom);
      bus.gt_accum_i = 21'($urandom);
      bus.lt_accum_i = 21'($urandom);
      bus.scale_i    = 17'($urandom);
      bus.offset_i   = 8'($urandom);
      stepClock();
    end

    // Asynchronous reset in the middle of FLUSH.
    $display("[TB] async reset in flush");
    settleIdle();
    bus.scale_i = 17'd8192;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 18; k++) stepClock();
    checkOutput("flush_busy",  32'(bus.busy_o),   32'd1);
    checkOutput("flush_ce",    32'(bus.agc_ce_o), 32'd0);
    #2 rst = 1'b1;
    #1 modelReset();
    checkAll();
    checkOutput("async_scale_unity", 32'(bus.agc_scale_o), 32'd4096);
    checkOutput("async_busy",        32'(bus.busy_o),      32'd0);
    stepClock();
    rst = 1'b0;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      stepClock();
      early += int'(bus.done_o);
    end
    checkOutput("async_no_done", 32'(early), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
